// File: rtl/eq_audio_pkg.sv
// rtl/eq_audio_pkg.sv - shared types and constants for the equalizer audio output path
package eq_audio_pkg;

    localparam int AUDIO_DATA_W   = 24;
    localparam int I2S_SLOT_W     = 32;
    localparam int I2S_FRAME_BITS = 2 * I2S_SLOT_W;

    typedef struct packed {
        logic [AUDIO_DATA_W-1:0] l;
        logic [AUDIO_DATA_W-1:0] r;
    } stereo_sample_t;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM
    } i2s_tx_state_t;

endpackage

// File: rtl/stereo_sample_fifo.sv
// rtl/stereo_sample_fifo.sv - synchronous FIFO of stereo sample pairs with occupancy level
module stereo_sample_fifo
    import eq_audio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  stereo_sample_t           wdata,
    output stereo_sample_t           rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    stereo_sample_t mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the same cycle frees a slot.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/eq_i2s_tx.sv
// rtl/eq_i2s_tx.sv - buffered I2S transmitter pacing the EQ pipeline with a per-frame sample request
module eq_i2s_tx
    import eq_audio_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = AUDIO_DATA_W,
    parameter int BCLK_DIV   = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          run,
    input  logic                          l_data_valid,
    input  logic                          r_data_valid,
    input  logic [DATA_W-1:0]             l_data_in,
    input  logic [DATA_W-1:0]             r_data_in,
    output logic                          sample_req,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic                          overrun
);

    localparam int          LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int          DIV_W  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [4:0]  LAST_P = 5'(DATA_W);

    i2s_tx_state_t      state_q;
    i2s_tx_state_t      state_d;
    logic [DIV_W-1:0]   div_cnt;
    logic [5:0]         bit_cnt;
    logic [5:0]         bit_nxt;
    logic [4:0]         slot_pos;
    logic [DATA_W-1:0]  slot_word;
    stereo_sample_t     tx_pair;
    stereo_sample_t     push_pair;
    stereo_sample_t     fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic               tick;
    logic               fall;
    logic               frame_start;
    logic               pop;
    logic               push_req;
    logic               push;
    logic               sdata_nxt;
    logic               underrun_d;
    logic               overrun_d;

    assign tick        = (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign fall        = tick && bclk;
    assign frame_start = fall && (bit_cnt == 6'(I2S_FRAME_BITS - 1));
    assign bit_nxt     = bit_cnt + 1'b1;

    // Serial bit for the position bit_cnt is about to enter; one-bit I2S delay after the slot edge.
    assign slot_pos  = bit_nxt[4:0];
    assign slot_word = bit_nxt[5] ? tx_pair.r : tx_pair.l;
    assign sdata_nxt = (slot_pos != 5'd0 && slot_pos <= LAST_P) ? slot_word[LAST_P - slot_pos] : 1'b0;

    assign push_pair.l = l_data_in;
    assign push_pair.r = r_data_in;
    assign push_req    = l_data_valid && r_data_valid && run;
    assign push        = push_req && (!fifo_full || pop);
    assign overrun_d   = push_req && fifo_full && !pop;

    stereo_sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!run),
        .push    (push),
        .pop     (pop),
        .wdata   (push_pair),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        underrun_d = 1'b0;
        case (state_q)
            IDLE: state_d = PRIME;
            PRIME: begin
                if (frame_start && fifo_level >= LVL_W'(2)) begin
                    pop     = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (frame_start) begin
                    if (fifo_empty) begin
                        underrun_d = 1'b1;
                        state_d    = PRIME;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!run) begin
            state_d    = IDLE;
            pop        = 1'b0;
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stopping aborts mid-frame: every serial output returns to its idle level on the next edge.
    always_ff @(posedge clk) begin
        if (!reset_n || !run) begin
            div_cnt    <= '0;
            bclk       <= 1'b0;
            bit_cnt    <= 6'(I2S_FRAME_BITS - 1);
            lrclk      <= 1'b1;
            sdata      <= 1'b0;
            tx_pair    <= '0;
            sample_req <= 1'b0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sample_req <= frame_start;
            underrun   <= underrun_d;
            overrun    <= overrun_d;
            if (tick) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (fall) begin
                bit_cnt <= bit_nxt;
                lrclk   <= bit_nxt[5];
                sdata   <= sdata_nxt;
            end
            if (frame_start) begin
                tx_pair <= pop ? fifo_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_eq_i2s_tx.sv
// tb/tb_eq_i2s_tx.sv - scoreboard bench decoding the I2S stream of eq_i2s_tx
module tb_eq_i2s_tx;
    import eq_audio_pkg::*;

    localparam int FIFO_DEPTH = 4;
    localparam int DATA_W     = 24;
    localparam int BCLK_DIV   = 2;
    localparam int FRAME_CLK  = 128 * BCLK_DIV;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              run;
    logic              l_data_valid;
    logic              r_data_valid;
    logic [DATA_W-1:0] l_data_in;
    logic [DATA_W-1:0] r_data_in;
    logic              sample_req;
    logic              bclk;
    logic              lrclk;
    logic              sdata;
    logic [2:0]        fifo_level;
    logic              underrun;
    logic              overrun;

    int n_checks = 0;
    int n_errors = 0;
    int under_cnt = 0;
    int over_cnt = 0;
    int n_pairs = 0;
    int zero_frames = 0;
    int oc0;

    stereo_sample_t sb[$];

    eq_i2s_tx #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (DATA_W),
        .BCLK_DIV   (BCLK_DIV)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .run          (run),
        .l_data_valid (l_data_valid),
        .r_data_valid (r_data_valid),
        .l_data_in    (l_data_in),
        .r_data_in    (r_data_in),
        .sample_req   (sample_req),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // I2S receiver: samples on bclk rise, slot restarts at each lrclk change.
    logic           bclk_prev = 1'b0;
    logic           prev_lr   = 1'b1;
    logic           left_ok   = 1'b0;
    logic           pad_bad   = 1'b0;
    int             pos       = 0;
    logic [23:0]    word      = '0;
    logic [23:0]    left_word = '0;
    stereo_sample_t mon_exp;

    always @(negedge clk) begin
        if (underrun) under_cnt++;
        if (overrun)  over_cnt++;
        if (bclk && !bclk_prev) begin
            if (lrclk != prev_lr) begin
                pos     = 0;
                pad_bad = 1'b0;
            end else begin
                pos++;
            end
            prev_lr = lrclk;
            if (pos >= 1 && pos <= DATA_W) word = {word[22:0], sdata};
            else if (sdata) pad_bad = 1'b1;
            if (pos == 31) begin
                check("slot_pad", pad_bad, 0);
                if (!lrclk) begin
                    left_word = word;
                    left_ok   = 1'b1;
                end else if (left_ok) begin
                    left_ok = 1'b0;
                    if (left_word == 0 && word == 0) begin
                        zero_frames++;
                    end else if (sb.size() == 0) begin
                        check("unexpected_pair", {left_word, word}, 0);
                    end else begin
                        mon_exp = sb.pop_front();
                        check("left", left_word, mon_exp.l);
                        check("right", word, mon_exp.r);
                        n_pairs++;
                    end
                end
            end
        end
        bclk_prev = bclk;
    end

    task automatic push_pair(input logic [23:0] ld, input logic [23:0] rd, input bit stored);
        l_data_in    = ld;
        r_data_in    = rd;
        l_data_valid = 1'b1;
        r_data_valid = 1'b1;
        if (stored) sb.push_back('{l: ld, r: rd});
        @(negedge clk);
        l_data_valid = 1'b0;
        r_data_valid = 1'b0;
    endtask

    task automatic push_rand(input bit stored);
        push_pair(24'($urandom) | 24'h1, 24'($urandom) | 24'h2, stored);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_req && n < 2 * FRAME_CLK);
        check(tag, sample_req, 1);
    endtask

    task automatic wait_underrun(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!underrun && n < 5 * FRAME_CLK);
        check(tag, underrun, 1);
    endtask

    initial begin
        reset_n = 1'b0; run = 1'b0;
        l_data_valid = 1'b0; r_data_valid = 1'b0;
        l_data_in = '0; r_data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bclk", bclk, 0);
        check("rst_lrclk", lrclk, 1);
        check("rst_sdata", sdata, 0);
        check("rst_level", fifo_level, 0);
        check("rst_strobes", {sample_req, underrun, overrun}, 0);
        reset_n = 1'b1;
        run     = 1'b1;
        @(negedge clk);
        check("bclk_low_1clk", bclk, 0);
        @(negedge clk);
        check("bclk_rise_2clk", bclk, 1);
        check("no_req_before_fall", sample_req, 0);

        // Two pairs queued during the priming frame, streamed from the next one.
        wait_req("t2_first_req");
        check("t2_frame_lrclk", lrclk, 0);
        push_pair(24'hA5A5A5, 24'h5A5A5A, 1);
        push_pair(24'h123456, 24'hFEDCBA, 1);
        check("t2_level", fifo_level, 2);
        wait_req("t2_stream_req");
        check("t2_level_after_pop", fifo_level, 1);

        for (int i = 0; i < 10; i++) begin
            push_rand(1);
            wait_req("t3_req");
            check("t3_level_range", (fifo_level >= 1 && fifo_level <= 2), 1);
        end

        wait_underrun("t4_underrun");
        check("t4_pairs", n_pairs, 12);
        check("t4_sb_empty", sb.size(), 0);
        check("t4_level", fifo_level, 0);
        wait_req("t4_prime_req1");
        wait_req("t4_prime_req2");
        check("t4_underrun_once", under_cnt, 1);
        check("t4_zero_frames", zero_frames >= 2, 1);
        for (int i = 0; i < 6; i++) begin
            push_rand(1);
            wait_req("t4_resume_req");
        end
        wait_underrun("t4_underrun2");
        check("t4_resume_pairs", n_pairs, 18);
        check("t4_resume_sb_empty", sb.size(), 0);
        check("t4_overrun_none", over_cnt, 0);

        oc0 = over_cnt;
        for (int i = 0; i < 4; i++) push_rand(1);
        check("t5_level_full", fifo_level, 4);
        push_rand(0);
        check("t5_overrun_strobe", overrun, 1);
        check("t5_level_sat", fifo_level, 4);
        repeat (250) @(negedge clk);
        check("t5_overrun_once", over_cnt - oc0, 1);
        push_rand(1);
        check("t5_fs_align", sample_req, 1);
        check("t5_level_pushpop", fifo_level, 4);
        check("t5_no_overrun", overrun, 0);

        repeat (161) @(negedge clk);
        run = 1'b0;
        sb.delete();
        @(negedge clk);
        check("t6_bclk", bclk, 0);
        check("t6_lrclk", lrclk, 1);
        check("t6_sdata", sdata, 0);
        check("t6_level", fifo_level, 0);
        check("t6_strobes", {sample_req, underrun, overrun}, 0);
        run = 1'b1;
        wait_req("t6_restart_req");
        check("t6_restart_lrclk", lrclk, 0);
        push_rand(1);
        push_rand(1);
        wait_req("t6_stream_req");
        check("t6_level_after_pop", fifo_level, 1);
        wait_req("t6_req2");
        wait_req("t6_req3");
        check("t6_pairs", n_pairs, 20);
        check("t6_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
